// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM encodings and sizing helper for the handshake FIFO
package spi_pkg;

    typedef enum logic {
        IDLE_WR = 1'b0,
        ACK_WR  = 1'b1
    } wr_state_t;

    typedef enum logic {
        IDLE_RD = 1'b0,
        RESP_RD = 1'b1
    } rd_state_t;

    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_fifo_ptr.sv
// rtl/spi_fifo_ptr.sv - head/tail pointers, entry count, overwrite counter and status flags
module spi_fifo_ptr
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int REG_WIDTH  = 16,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 1,
    parameter int ADDR_W     = log2_ceil(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push,
    input  logic                 pop,
    output logic [ADDR_W-1:0]    head,
    output logic [ADDR_W-1:0]    tail,
    output logic [REG_WIDTH-1:0] occupancy,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [REG_WIDTH-1:0] overflow_cnt
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    logic [CNT_W-1:0] count;

    // A push while full can only be an overwrite; the write side never lets it
    // coincide with a pop, so the head moves at most once per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            overflow_cnt <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop || (push && full)) begin
                head <= head + 1'b1;
            end
            if (push && !pop && !full) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (push && full && !(&overflow_cnt)) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end
        end
    end

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign occupancy    = REG_WIDTH'(count);

endmodule

// File: rtl/spi_fifo_hs.sv
// rtl/spi_fifo_hs.sv - FIFO with req/ack write port and req/resp/ack read port
module spi_fifo_hs
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int REG_WIDTH  = 16,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  allow_overwrite_i,
    input  logic                  req_a_i,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    output logic                  ack_a_o,
    input  logic                  req_b_i,
    output logic [DATA_WIDTH-1:0] data_b_o,
    output logic                  resp_b_o,
    input  logic                  ack_b_i,
    output logic [REG_WIDTH-1:0]  fifo_occupancy_o,
    output logic                  fifo_full_o,
    output logic                  fifo_empty_o,
    output logic                  fifo_almost_full_o,
    output logic                  fifo_almost_empty_o,
    output logic [REG_WIDTH-1:0]  overflow_cnt_o
);

    localparam int ADDR_W = log2_ceil(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]     head;
    logic [ADDR_W-1:0]     tail;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;
    logic      push;
    logic      pop;
    logic      load;
    logic      read_hold;

    assign read_hold = (rd_state == RESP_RD);

    always_comb begin
        wr_next = wr_state;
        push    = 1'b0;
        case (wr_state)
            IDLE_WR: begin
                if (req_a_i && (!fifo_full_o || (allow_overwrite_i && !read_hold))) begin
                    push    = 1'b1;
                    wr_next = ACK_WR;
                end
            end
            ACK_WR:  wr_next = IDLE_WR;
            default: wr_next = IDLE_WR;
        endcase
        if (flush_i) begin
            push    = 1'b0;
            wr_next = IDLE_WR;
        end
    end

    always_comb begin
        rd_next = rd_state;
        load    = 1'b0;
        pop     = 1'b0;
        case (rd_state)
            IDLE_RD: begin
                if (req_b_i && !fifo_empty_o) begin
                    load    = 1'b1;
                    rd_next = RESP_RD;
                end
            end
            RESP_RD: begin
                if (ack_b_i) begin
                    pop     = 1'b1;
                    rd_next = IDLE_RD;
                end
            end
            default: rd_next = IDLE_RD;
        endcase
        if (flush_i) begin
            load    = 1'b0;
            pop     = 1'b0;
            rd_next = IDLE_RD;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state <= IDLE_WR;
            rd_state <= IDLE_RD;
            data_b_o <= '0;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
            if (flush_i) begin
                data_b_o <= '0;
            end else if (load) begin
                data_b_o <= mem[head];
            end
        end
    end

    // Storage carries no reset; stale words are never visible past the count.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem[tail] <= data_a_i;
        end
    end

    assign ack_a_o  = (wr_state == ACK_WR);
    assign resp_b_o = (rd_state == RESP_RD);

    spi_fifo_ptr #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .REG_WIDTH  (REG_WIDTH),
        .AF_THRESH  (AF_THRESH),
        .AE_THRESH  (AE_THRESH),
        .ADDR_W     (ADDR_W)
    ) u_ptr (
        .clk          (clk_i),
        .rst          (rst_i),
        .flush        (flush_i),
        .push         (push),
        .pop          (pop),
        .head         (head),
        .tail         (tail),
        .occupancy    (fifo_occupancy_o),
        .full         (fifo_full_o),
        .empty        (fifo_empty_o),
        .almost_full  (fifo_almost_full_o),
        .almost_empty (fifo_almost_empty_o),
        .overflow_cnt (overflow_cnt_o)
    );

endmodule

// File: tb/tb_spi_fifo_hs.sv
// tb/tb_spi_fifo_hs.sv - vector table plus scoreboard bench for spi_fifo_hs
module tb_spi_fifo_hs;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int RW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          allow = 1'b0;
    logic          req_a = 1'b0;
    logic [DW-1:0] data_a = '0;
    logic          ack_a;
    logic          req_b = 1'b0;
    logic [DW-1:0] data_b;
    logic          resp_b;
    logic          ack_b = 1'b0;
    logic [RW-1:0] occ;
    logic          full, empty, af, ae;
    logic [RW-1:0] ovf;

    int            vec_cnt = 0;
    int            err_cnt = 0;
    logic [DW-1:0] exp_q[$];
    int            exp_ovf = 0;

    typedef struct {
        bit            is_write;
        logic [DW-1:0] d;
        logic [RW-1:0] occ;
        logic          full;
        logic          empty;
        logic          af;
        logic          ae;
    } vec_t;

    vec_t tbl[8];

    spi_fifo_hs #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .REG_WIDTH  (RW),
        .AF_THRESH  (3),
        .AE_THRESH  (1)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .flush_i             (flush),
        .allow_overwrite_i   (allow),
        .req_a_i             (req_a),
        .data_a_i            (data_a),
        .ack_a_o             (ack_a),
        .req_b_i             (req_b),
        .data_b_o            (data_b),
        .resp_b_o            (resp_b),
        .ack_b_i             (ack_b),
        .fifo_occupancy_o    (occ),
        .fifo_full_o         (full),
        .fifo_empty_o        (empty),
        .fifo_almost_full_o  (af),
        .fifo_almost_empty_o (ae),
        .overflow_cnt_o      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(input logic [DW-1:0] d);
        if (exp_q.size() == DEPTH) begin
            void'(exp_q.pop_front());
            exp_ovf++;
        end
        exp_q.push_back(d);
    endtask

    task automatic do_write(input logic [DW-1:0] d);
        int n;
        n = 0;
        req_a  = 1'b1;
        data_a = d;
        do begin
            tick();
            n++;
        end while (!ack_a && n < 20);
        req_a = 1'b0;
        check("wr_ack_seen", ack_a, 1);
        if (ack_a) model_push(d);
    endtask

    task automatic read_start();
        int n;
        logic [DW-1:0] e;
        n = 0;
        req_b = 1'b1;
        do begin
            tick();
            n++;
        end while (!resp_b && n < 20);
        check("rd_resp_seen", resp_b, 1);
        if (resp_b) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            check("rd_data", data_b, e);
        end
    endtask

    task automatic read_finish();
        req_b = 1'b0;
        ack_b = 1'b1;
        tick();
        ack_b = 1'b0;
        check("rd_resp_drop", resp_b, 0);
    endtask

    task automatic do_read();
        read_start();
        read_finish();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_values();
        check("rst_occ", occ, 0);
        check("rst_ovf", ovf, 0);
        check("rst_ack_a", ack_a, 0);
        check("rst_resp_b", resp_b, 0);
        check("rst_data_b", data_b, 0);
        check("rst_empty", empty, 1);
        check("rst_ae", ae, 1);
        check("rst_full", full, 0);
        check("rst_af", af, 0);
    endtask

    initial begin
        // fill then drain: occupancy and flag expectations after each operation
        tbl[0] = '{1'b1, 16'hA1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 16'hA2, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 16'hA3, 16'd3, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 16'hA4, 16'd4, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 16'h00, 16'd3, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 16'h00, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 16'h00, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 16'h00, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_values();

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].is_write) do_write(tbl[i].d);
            else                 do_read();
            check("tbl_occ", occ, tbl[i].occ);
            check("tbl_full", full, tbl[i].full);
            check("tbl_empty", empty, tbl[i].empty);
            check("tbl_af", af, tbl[i].af);
            check("tbl_ae", ae, tbl[i].ae);
        end

        // full without overwrite: write stalls until a read frees a slot
        for (int i = 0; i < DEPTH; i++) do_write(16'hA1 + 16'(i));
        tick();
        check("ack_one_cycle", ack_a, 0);
        allow  = 1'b0;
        req_a  = 1'b1;
        data_a = 16'hB5;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_no_ack", ack_a, 0);
        end
        do_read();
        begin
            int n;
            n = 0;
            do begin
                tick();
                n++;
            end while (!ack_a && n < 20);
            req_a = 1'b0;
            check("stall_release_ack", ack_a, 1);
            if (ack_a) model_push(16'hB5);
        end
        check("stall_occ", occ, 4);
        ack_b = 1'b1;
        tick();
        ack_b = 1'b0;
        check("stray_ack_occ", occ, 4);
        check("stray_ack_resp", resp_b, 0);
        do_flush();

        // overwrite when full drops the oldest entry
        for (int i = 0; i < DEPTH; i++) do_write(16'hA1 + 16'(i));
        allow = 1'b1;
        do_write(16'hB5);
        allow = 1'b0;
        check("ovw_occ", occ, 4);
        check("ovw_cnt", ovf, exp_ovf);
        check("ovw_cnt_one", ovf, 1);
        for (int i = 0; i < DEPTH; i++) do_read();
        check("ovw_drained", empty, 1);

        // write and pop in the same cycle keep occupancy, order survives wrap
        do_flush();
        do_write(16'hD0);
        do_write(16'hD1);
        for (int k = 0; k < 6; k++) begin
            read_start();
            req_b  = 1'b0;
            ack_b  = 1'b1;
            req_a  = 1'b1;
            data_a = 16'hD2 + 16'(k);
            tick();
            ack_b = 1'b0;
            req_a = 1'b0;
            check("simul_occ", occ, 2);
            check("simul_ack", ack_a, 1);
            if (ack_a) model_push(16'hD2 + 16'(k));
        end
        do_read();
        do_read();
        check("simul_drained", occ, 0);

        // read request on empty waits; response follows the write by one cycle
        req_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("empty_no_resp", resp_b, 0);
        end
        req_a  = 1'b1;
        data_a = 16'hC3;
        begin
            int n;
            n = 0;
            do begin
                tick();
                n++;
            end while (!ack_a && n < 20);
            req_a = 1'b0;
            check("c3_ack", ack_a, 1);
            if (ack_a) model_push(16'hC3);
        end
        check("c3_resp_not_yet", resp_b, 0);
        tick();
        check("c3_resp", resp_b, 1);
        check("c3_data", data_b, (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx);
        read_finish();

        // flush in the middle of a response, with competing requests
        do_write(16'hE1);
        do_write(16'hE2);
        do_write(16'hE3);
        read_start();
        req_a  = 1'b1;
        data_a = 16'hFF;
        flush  = 1'b1;
        tick();
        flush = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        exp_q.delete();
        check("flush_occ", occ, 0);
        check("flush_resp", resp_b, 0);
        check("flush_ack_a", ack_a, 0);
        check("flush_data_b", data_b, 0);
        check("flush_empty", empty, 1);
        check("flush_ovf_kept", ovf, exp_ovf);

        do_write(16'h55);
        rst   = 1'b1;
        flush = 1'b1;
        req_b = 1'b1;
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        req_b = 1'b0;
        exp_q.delete();
        exp_ovf = 0;
        check_reset_values();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/spi_fifo_hs.md
SPI_FIFO_HS -- requirements
Module: spi_fifo_hs

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, data word width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, number of entries; power of two, >=2; address width derived as log2(FIFO_DEPTH).
REQ-003 SHALL have parameter REG_WIDTH, default 16, width of status/counter outputs; >= log2(FIFO_DEPTH)+1.
REQ-004 SHALL have parameter AF_THRESH, default FIFO_DEPTH-2, almost-full level.
REQ-005 SHALL have parameter AE_THRESH, default 1, almost-empty level.
REQ-006 clk_i  in  1  single clock; all logic on rising edge.
REQ-007 rst_i  in  1  reset: synchronous, active-high.
REQ-008 flush_i  in  1  synchronous content flush, active-high.
REQ-009 allow_overwrite_i  in  1  when full, a write replaces the oldest entry.
REQ-010 req_a_i / data_a_i / ack_a_o  in 1 / in DATA_WIDTH / out 1  write request, write data, write acknowledge.
REQ-011 req_b_i / data_b_o / resp_b_o / ack_b_i  in 1 / out DATA_WIDTH / out 1 / in 1  read request, read data, read response, read acknowledge.
REQ-012 fifo_occupancy_o  out  REG_WIDTH  entry count, zero-extended.
REQ-013 fifo_full_o, fifo_empty_o, fifo_almost_full_o, fifo_almost_empty_o  out  1 each  status flags.
REQ-014 overflow_cnt_o  out  REG_WIDTH  count of overwrite events, saturating.

Function
REQ-015 Flags SHALL be combinational from the registered count: full = (count==FIFO_DEPTH); empty = (count==0); almost_full = (count>=AF_THRESH); almost_empty = (count<=AE_THRESH).
REQ-016 Write FSM SHALL have states IDLE_WR, ACK_WR; IDLE_WR accepts when req_a_i & (~full | (allow_overwrite_i & ~read_hold)), where read_hold = read FSM in RESP_RD.
REQ-017 On acceptance: data_a_i written to mem[tail] that cycle, tail+1 (wraps modulo FIFO_DEPTH), ack_a_o=1 next cycle, state -> ACK_WR.
REQ-018 ACK_WR SHALL last exactly one cycle, ack_a_o deasserted after it, return to IDLE_WR; max one write per two cycles.
REQ-019 Full-and-not-allowed or full-and-read_hold writes SHALL stall (no ack, no state change) until the condition clears; req_a_i held by the master.
REQ-020 Overwrite acceptance (full): tail+1, head+1, count unchanged, overflow_cnt +1 saturating at all-ones.
REQ-021 Read FSM SHALL have states IDLE_RD, RESP_RD; IDLE_RD with req_b_i & ~empty: data_b_o <= mem[head], resp_b_o <= 1, -> RESP_RD; req_b_i while empty waits (no response).
REQ-022 RESP_RD SHALL hold data_b_o and resp_b_o stable until ack_b_i; on ack_b_i: head+1 (wrap), count-1, resp_b_o <= 0, -> IDLE_RD.
REQ-023 ack_b_i outside RESP_RD SHALL be ignored.
REQ-024 Same-cycle write acceptance and read pop SHALL advance both pointers with count unchanged.
REQ-025 Latency: empty FIFO, write accepted cycle N -> read request accepted no earlier than N+1, resp_b_o high N+2.
REQ-026 flush_i SHALL zero head, tail, count, return both FSMs to idle, drop ack_a_o/resp_b_o, clear data_b_o; overflow_cnt_o retained; flush has priority over same-cycle requests.

Reset
REQ-027 With rst_i high at clk_i edge: head=tail=count=0, overflow_cnt_o=0, ack_a_o=0, resp_b_o=0, data_b_o=0, FSMs idle; empty=1, almost_empty=1, full=0, almost_full=0 (AF_THRESH>0).
REQ-028 rst_i SHALL override flush_i and all requests; reset mid-transaction aborts it with no pointer movement.
REQ-029 Storage array SHALL not be reset.

Structure
REQ-030 FSM state encodings and a log2 helper SHALL live in shared package spi_pkg.
REQ-031 One sub-module spi_fifo_ptr (pointers, count, overflow counter, flags) is natural; storage and FSMs stay in spi_fifo_hs.

Verification (DATA_WIDTH=16, FIFO_DEPTH=4, AF_THRESH=3, AE_THRESH=1)
REQ-032 Write 0xA1,0xA2,0xA3,0xA4 -> four ack pulses, occupancy 4, full=1, almost_full from 3rd write; then four reads return A1..A4 in order, empty=1.
REQ-033 Full, allow_overwrite_i=0, write 0xB5 -> no ack while full; one read completes -> write acked next eligible cycle, occupancy 4.
REQ-034 Full with A1..A4, allow_overwrite_i=1, write 0xB5 -> ack, occupancy 4, overflow_cnt_o=1; reads return A2,A3,A4,B5.
REQ-035 Occupancy 2, write accepted same cycle as ack_b_i -> occupancy stays 2, order preserved across pointer wrap.
REQ-036 req_b_i on empty FIFO -> resp_b_o stays 0; write 0xC3 -> resp_b_o rises, data_b_o=0xC3.
REQ-037 flush_i mid RESP_RD with occupancy 3, overflow_cnt_o=1 -> next cycle occupancy 0, resp_b_o 0, overflow_cnt_o 1; rst_i -> all REQ-027 values.
